// File: rtl/bsg_dfi_fifo_responder.sv
// Memory-side endpoint of the DFI-over-FIFO link: decodes DDR commands, tracks open rows,
// and expands BL8 bursts into word requests with a credit-limited read return FIFO.
module bsg_dfi_fifo_responder #(
   parameter int dq_data_width_p = 32,
   parameter int row_width_p     = 16,
   parameter int col_width_p     = 10,
   localparam int dq_group_lp    = dq_data_width_p >> 3,
   localparam int word_w_lp      = 2*dq_data_width_p,
   localparam int mask_w_lp      = 2*dq_group_lp,
   localparam int addr_w_lp      = 3+row_width_p+col_width_p-1
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 cmd_v_i,
   input  logic [25:0]          cmd_data_i,
   output logic                 cmd_yumi_o,
   input  logic                 wr_v_i,
   input  logic [word_w_lp+mask_w_lp-1:0] wr_data_i,
   output logic                 wr_yumi_o,
   output logic                 rd_v_o,
   output logic [word_w_lp-1:0] rd_data_o,
   input  logic                 rd_yumi_i,
   output logic                 mem_v_o,
   output logic                 mem_w_o,
   output logic [addr_w_lp-1:0] mem_addr_o,
   output logic [word_w_lp-1:0] mem_data_o,
   output logic [mask_w_lp-1:0] mem_mask_o,
   input  logic                 mem_ready_i,
   input  logic                 mem_rd_v_i,
   input  logic [word_w_lp-1:0] mem_rd_data_i,
   output logic                 error_o
);

   typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2} state_e;

   state_e                  r_state, w_state_n;
   logic [7:0]              r_open;
   logic [row_width_p-1:0]  r_row [8];
   logic [2:0]              r_bank;
   logic [col_width_p-4:0]  r_col;
   logic                    r_ap;
   logic [1:0]              r_beat;
   logic [3:0]              r_credits, r_outstanding, r_count;
   logic [2:0]              r_wptr, r_rptr;
   logic [word_w_lp-1:0]    r_mem [8];
   logic                    r_error;

   logic [2:0]  w_bank, w_rcw;
   logic [15:0] w_addr;
   logic        w_cke, w_cs_n, w_reset_n, w_unused_odt;
   logic        w_sel, w_is_act, w_is_pre, w_is_rd, w_is_wr, w_close_all;
   logic        w_burst_ok, w_burst_bad, w_act_err;
   logic        w_mem_fire, w_last, w_rd_accept, w_push, w_pop, w_err;

   assign w_bank       = cmd_data_i[25:23];
   assign w_addr       = cmd_data_i[22:7];
   assign w_cke        = cmd_data_i[6];
   assign w_cs_n       = cmd_data_i[5];
   assign w_rcw        = cmd_data_i[4:2];
   assign w_reset_n    = cmd_data_i[1];
   assign w_unused_odt = cmd_data_i[0];

   // A command with reset_n low only closes banks; deselected or clock-disabled commands are dropped
   assign w_sel       = cmd_yumi_o & w_cke & ~w_cs_n & w_reset_n;
   assign w_close_all = cmd_yumi_o & ~w_reset_n;
   assign w_is_act    = w_sel & (w_rcw == 3'b011);
   assign w_is_pre    = w_sel & (w_rcw == 3'b010);
   assign w_is_wr     = w_sel & (w_rcw == 3'b100);
   assign w_is_rd     = w_sel & (w_rcw == 3'b101);
   assign w_burst_ok  = (w_is_rd | w_is_wr) & r_open[w_bank];
   assign w_burst_bad = (w_is_rd | w_is_wr) & ~r_open[w_bank];
   assign w_act_err   = w_is_act & r_open[w_bank];

   assign w_mem_fire  = mem_v_o & mem_ready_i;
   assign w_last      = w_mem_fire & (r_beat == 2'd3);
   assign w_rd_accept = w_mem_fire & (r_state == READ);
   assign w_push      = mem_rd_v_i & (r_outstanding != 4'd0);
   assign w_pop       = rd_yumi_i & (r_count != 4'd0);
   assign w_err       = w_act_err | w_burst_bad | (mem_rd_v_i & (r_outstanding == 4'd0));

   assign mem_addr_o  = {r_bank, r_row[r_bank], r_col, r_beat};
   assign rd_v_o      = (r_count != 4'd0);
   assign rd_data_o   = r_mem[r_rptr];
   assign error_o     = r_error;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) r_state <= IDLE;
      else         r_state <= w_state_n;
   end

   always_comb begin
      w_state_n = r_state;
      case (r_state)
         IDLE:        if (w_burst_ok) w_state_n = w_is_rd ? READ : WRITE;
                      else            w_state_n = IDLE;
         READ, WRITE: if (w_last)     w_state_n = IDLE;
                      else            w_state_n = r_state;
         default:     w_state_n = IDLE;
      endcase
   end

   always_comb begin
      cmd_yumi_o = 1'b0;
      wr_yumi_o  = 1'b0;
      mem_v_o    = 1'b0;
      mem_w_o    = 1'b0;
      mem_data_o = {word_w_lp{1'b0}};
      mem_mask_o = {mask_w_lp{1'b0}};
      case (r_state)
         IDLE:  cmd_yumi_o = cmd_v_i;
         WRITE: begin
            mem_v_o    = wr_v_i;
            mem_w_o    = 1'b1;
            mem_data_o = wr_data_i[word_w_lp+mask_w_lp-1:mask_w_lp];
            mem_mask_o = ~wr_data_i[mask_w_lp-1:0];
            wr_yumi_o  = wr_v_i & mem_ready_i;
         end
         READ: begin
            mem_v_o    = (r_credits != 4'd0);
            mem_mask_o = {mask_w_lp{1'b1}};
         end
         default: cmd_yumi_o = 1'b0;
      endcase
   end

   // Commands are only decoded in IDLE and bursts only retire outside it, so these never collide
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_open <= 8'h00;
         for (int i = 0; i < 8; i++) r_row[i] <= {row_width_p{1'b0}};
         r_bank <= 3'd0;
         r_col  <= {(col_width_p-3){1'b0}};
         r_ap   <= 1'b0;
         r_beat <= 2'd0;
      end else begin
         if (w_close_all) r_open <= 8'h00;
         if (w_is_act) begin
            r_open[w_bank] <= 1'b1;
            r_row[w_bank]  <= w_addr[row_width_p-1:0];
         end
         if (w_is_pre) begin
            if (w_addr[10]) r_open <= 8'h00;
            else            r_open[w_bank] <= 1'b0;
         end
         if (w_burst_ok) begin
            r_bank <= w_bank;
            r_col  <= w_addr[col_width_p-1:3];
            r_ap   <= w_addr[10];
            r_beat <= 2'd0;
         end
         if (w_mem_fire) r_beat <= r_beat + 2'd1;
         if (w_last && r_ap) r_open[r_bank] <= 1'b0;
      end
   end

   // Credits bound issued reads to the free return-FIFO space; both counters saturate
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_credits     <= 4'd8;
         r_outstanding <= 4'd0;
         r_count       <= 4'd0;
         r_wptr        <= 3'd0;
         r_rptr        <= 3'd0;
         r_error       <= 1'b0;
      end else begin
         case ({w_rd_accept, w_pop})
            2'b10:   if (r_credits != 4'd0)  r_credits <= r_credits - 4'd1;
            2'b01:   if (r_credits != 4'd15) r_credits <= r_credits + 4'd1;
            default: r_credits <= r_credits;
         endcase
         case ({w_rd_accept, w_push})
            2'b10:   if (r_outstanding != 4'd15) r_outstanding <= r_outstanding + 4'd1;
            2'b01:   r_outstanding <= r_outstanding - 4'd1;
            default: r_outstanding <= r_outstanding;
         endcase
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 4'd1;
            2'b01:   r_count <= r_count - 4'd1;
            default: r_count <= r_count;
         endcase
         if (w_push) r_wptr <= r_wptr + 3'd1;
         if (w_pop)  r_rptr <= r_rptr + 3'd1;
         if (w_err)  r_error <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wptr] <= mem_rd_data_i;
   end

endmodule

// File: tb/tb_bsg_dfi_fifo_responder.sv
// Directed bench for bsg_dfi_fifo_responder with a request scoreboard and a 3-cycle memory model.
module tb_bsg_dfi_fifo_responder;

   typedef struct packed {
      logic        w;
      logic [27:0] addr;
      logic [63:0] data;
      logic [7:0]  mask;
   } req_t;

   logic        clk = 1'b0;
   logic        reset_i = 1'b1;
   logic        cmd_v_i = 1'b0;
   logic [25:0] cmd_data_i = 26'd0;
   logic        cmd_yumi_o;
   logic        wr_v_i = 1'b0;
   logic [71:0] wr_data_i = 72'd0;
   logic        wr_yumi_o;
   logic        rd_v_o;
   logic [63:0] rd_data_o;
   logic        rd_yumi_i = 1'b0;
   logic        mem_v_o, mem_w_o;
   logic [27:0] mem_addr_o;
   logic [63:0] mem_data_o;
   logic [7:0]  mem_mask_o;
   logic        mem_ready_i = 1'b1;
   logic        mem_rd_v_i = 1'b0;
   logic [63:0] mem_rd_data_i = 64'd0;
   logic        error_o;

   int          checks = 0;
   int          errors = 0;
   req_t        exp_req [$];
   logic [63:0] exp_rd [$];
   logic [15:0] exp_row [8];

   bsg_dfi_fifo_responder dut (
      .clk_i(clk), .reset_i(reset_i),
      .cmd_v_i(cmd_v_i), .cmd_data_i(cmd_data_i), .cmd_yumi_o(cmd_yumi_o),
      .wr_v_i(wr_v_i), .wr_data_i(wr_data_i), .wr_yumi_o(wr_yumi_o),
      .rd_v_o(rd_v_o), .rd_data_o(rd_data_o), .rd_yumi_i(rd_yumi_i),
      .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .mem_mask_o(mem_mask_o), .mem_ready_i(mem_ready_i),
      .mem_rd_v_i(mem_rd_v_i), .mem_rd_data_i(mem_rd_data_i), .error_o(error_o)
   );

   always #5 clk = ~clk;

   function automatic logic [27:0] baddr(input logic [2:0] b, input logic [15:0] row,
                                         input logic [9:0] col, input logic [1:0] beat);
      return {b, row, col[9:3], beat};
   endfunction

   function automatic logic [63:0] rdat(input logic [27:0] a);
      return {4'hD, a, 4'hA, ~a};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Memory model and request scoreboard, sampled 1ns before each rising edge
   initial begin
      logic [2:0]  pv;
      logic [63:0] pd [3];
      req_t        e;
      pv = 3'b000;
      forever begin
         @(negedge clk);
         #4;
         if (reset_i) begin
            pv = 3'b000;
            mem_rd_v_i = 1'b0;
         end else begin
            mem_rd_v_i    = pv[2];
            mem_rd_data_i = pd[2];
            pv[2] = pv[1]; pd[2] = pd[1];
            pv[1] = pv[0]; pd[1] = pd[0];
            pv[0] = 1'b0;
            if (mem_v_o && mem_ready_i) begin
               checks++;
               assert (exp_req.size() != 0) else begin
                  errors++;
                  $error("FAIL unexpected_req: observed addr %0h expected no request", mem_addr_o);
               end
               if (exp_req.size() != 0) begin
                  e = exp_req.pop_front();
                  chk("req_w", mem_w_o, e.w);
                  chk("req_addr", mem_addr_o, e.addr);
                  chk("req_mask", mem_mask_o, e.mask);
                  if (e.w) chk("req_data", mem_data_o, e.data);
               end
               if (!mem_w_o) begin
                  pv[0] = 1'b1;
                  pd[0] = rdat(mem_addr_o);
               end
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic send_cmd(input logic [2:0] bank, input logic [15:0] addr, input logic [2:0] rcw);
      int n = 0;
      cmd_data_i = {bank, addr, 1'b1, 1'b0, rcw, 1'b1, 1'b0};
      cmd_v_i = 1'b1;
      #1;
      while (!cmd_yumi_o && n < 60) begin
         @(negedge clk); #1; n++;
      end
      chk("cmd_accept", cmd_yumi_o, 1'b1);
      @(negedge clk);
      cmd_v_i = 1'b0;
   endtask

   task automatic act(input logic [2:0] bank, input logic [15:0] row);
      exp_row[bank] = row;
      send_cmd(bank, row, 3'b011);
   endtask

   task automatic feed_write(input logic [2:0] bank, input logic [9:0] col, input int n, input bit stall);
      logic [63:0] dq [$];
      logic [7:0]  mq [$];
      req_t r;
      int got = 0, cyc = 0;
      for (int i = 0; i < n; i++) begin
         r.w = 1'b1;
         r.addr = baddr(bank, exp_row[bank], col, 2'(i));
         r.data = {$urandom, $urandom};
         mq.push_back(8'($urandom_range(0, 255)));
         dq.push_back(r.data);
         r.mask = ~mq[i];
         exp_req.push_back(r);
      end
      while (got < n && cyc < 100) begin
         wr_v_i = 1'b1;
         wr_data_i = {dq[got], mq[got]};
         mem_ready_i = !(stall && (cyc == 1 || cyc == 2));
         #1;
         if (wr_yumi_o) got++;
         @(negedge clk);
         cyc++;
      end
      wr_v_i = 1'b0;
      mem_ready_i = 1'b1;
      chk("wr_yumi_count", got, n);
   endtask

   task automatic do_write(input logic [2:0] bank, input logic [9:0] col, input bit stall);
      send_cmd(bank, {5'b00000, 1'b0, col}, 3'b100);
      feed_write(bank, col, 4, stall);
   endtask

   task automatic issue_read(input logic [2:0] bank, input logic [9:0] col, input logic ap);
      req_t r;
      for (int i = 0; i < 4; i++) begin
         r.w = 1'b0;
         r.addr = baddr(bank, exp_row[bank], col, 2'(i));
         r.data = 64'd0;
         r.mask = 8'hFF;
         exp_req.push_back(r);
         exp_rd.push_back(rdat(r.addr));
      end
      send_cmd(bank, {5'b00000, ap, col}, 3'b101);
   endtask

   task automatic drain(input int n);
      int got = 0, cyc = 0;
      while (got < n && cyc < 300) begin
         rd_yumi_i = rd_v_o;
         if (rd_v_o) begin
            if (exp_rd.size() != 0) chk("rd_data", rd_data_o, exp_rd.pop_front());
            got++;
         end
         @(negedge clk);
         cyc++;
      end
      rd_yumi_i = 1'b0;
      chk("rd_count", got, n);
   endtask

   task automatic do_reset();
      reset_i = 1'b1;
      cmd_v_i = 1'b0;
      wr_v_i = 1'b0;
      rd_yumi_i = 1'b0;
      mem_ready_i = 1'b1;
      exp_req.delete();
      exp_rd.delete();
      repeat (2) @(negedge clk);
      reset_i = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) exp_row[i] = 16'h0000;
      @(negedge clk);
      chk("rst_cmd_yumi", cmd_yumi_o, 1'b0);
      chk("rst_wr_yumi", wr_yumi_o, 1'b0);
      chk("rst_rd_v", rd_v_o, 1'b0);
      chk("rst_mem_v", mem_v_o, 1'b0);
      chk("rst_error", error_o, 1'b0);
      reset_i = 1'b0;
      @(negedge clk);

      // Write then read back through bank 2, with a refresh in between and a ready stall
      act(3'd2, 16'h1234);
      do_write(3'd2, 10'h008, 1'b1);
      send_cmd(3'd2, 16'h0000, 3'b001);
      issue_read(3'd2, 10'h008, 1'b0);
      drain(4);
      chk("rd_no_error", error_o, 1'b0);

      // Three reads with no pops: 8 credits then stall
      issue_read(3'd2, 10'h010, 1'b0);
      issue_read(3'd2, 10'h018, 1'b0);
      issue_read(3'd2, 10'h020, 1'b0);
      repeat (10) @(negedge clk);
      chk("credit_stall_mem_v", mem_v_o, 1'b0);
      chk("credit_pending_reqs", exp_req.size(), 4);
      chk("credit_fifo_v", rd_v_o, 1'b1);
      drain(12);
      chk("credit_no_error", error_o, 1'b0);

      // Read to a closed bank is dropped and sets a sticky error
      do_reset();
      chk("closed_rd_pre_err", error_o, 1'b0);
      send_cmd(3'd5, 16'h0008, 3'b101);
      chk("closed_rd_err", error_o, 1'b1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("closed_rd_no_mem_v", mem_v_o, 1'b0);
      end
      chk("closed_rd_err_sticky", error_o, 1'b1);

      // Double ACT flags error and reloads the row
      do_reset();
      act(3'd5, 16'h1111);
      chk("act_once_err", error_o, 1'b0);
      act(3'd5, 16'h2222);
      chk("act_twice_err", error_o, 1'b1);
      do_write(3'd5, 10'h010, 1'b0);

      // Auto-precharge read closes its bank
      do_reset();
      act(3'd1, 16'h0055);
      issue_read(3'd1, 10'h3F8, 1'b1);
      drain(4);
      chk("ap_rd_no_error", error_o, 1'b0);
      send_cmd(3'd1, 16'h0000, 3'b101);
      chk("ap_second_rd_err", error_o, 1'b1);

      // PRE with A10 closes every bank
      do_reset();
      act(3'd0, 16'h0100);
      act(3'd3, 16'h0300);
      act(3'd7, 16'h0700);
      send_cmd(3'd0, 16'h0400, 3'b010);
      act(3'd3, 16'h0033);
      act(3'd7, 16'h0077);
      chk("pre_all_reopen_ok", error_o, 1'b0);
      send_cmd(3'd0, 16'h0000, 3'b101);
      chk("pre_all_b0_closed", error_o, 1'b1);

      // Reset in the middle of a write burst
      do_reset();
      act(3'd4, 16'hBEEF);
      send_cmd(3'd4, 16'h0040, 3'b100);
      feed_write(3'd4, 10'h040, 2, 1'b0);
      wr_v_i = 1'b1;
      #1;
      chk("midwr_active", mem_v_o, 1'b1);
      reset_i = 1'b1;
      #1;
      chk("midwr_rst_mem_v", mem_v_o, 1'b0);
      chk("midwr_rst_wr_yumi", wr_yumi_o, 1'b0);
      do_reset();
      act(3'd4, 16'h0BAD);
      do_write(3'd4, 10'h040, 1'b0);
      repeat (3) @(negedge clk);
      chk("midwr_after_error", error_o, 1'b0);
      chk("final_req_queue", exp_req.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
